// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave front end
// Contents: spi_state_e frame FSM states, RAM opcode constants, default widths.
package spi_pkg;

   localparam int RX_WIDTH_DEF = 10;
   localparam int TX_WIDTH_DEF = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - parallel-load, MSB-first serializer driving MISO
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture tx_data_i; its MSB appears on miso_o the next cycle
//   abort_i     : drop any shift in progress, miso_o returns to 0
//   tx_data_i   : word to serialize
//   miso_o      : registered serial output, 0 when idle
//   done_o      : high during the cycle the last bit is on miso_o
module spi_tx_serializer #(
   parameter int TX_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic                abort_i,
   input  logic [TX_WIDTH-1:0] tx_data_i,
   output logic                miso_o,
   output logic                done_o
);

   localparam int CW = $clog2(TX_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(TX_WIDTH - 1);

   logic                busy_q;
   logic                miso_q;
   logic [CW-1:0]       cnt_q;
   // Holds only the bits not yet presented; the MSB goes straight to miso_q.
   logic [TX_WIDTH-2:0] sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         miso_q <= 1'b0;
         cnt_q  <= '0;
         sh_q   <= '0;
      end else if (abort_i) begin
         busy_q <= 1'b0;
         miso_q <= 1'b0;
         cnt_q  <= '0;
      end else if (load_i && !busy_q) begin
         busy_q <= 1'b1;
         miso_q <= tx_data_i[TX_WIDTH-1];
         sh_q   <= tx_data_i[TX_WIDTH-2:0];
         cnt_q  <= '0;
      end else if (busy_q) begin
         if (cnt_q == LAST) begin
            busy_q <= 1'b0;
            miso_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            miso_q <= sh_q[TX_WIDTH-2];
            sh_q   <= {sh_q[TX_WIDTH-3:0], 1'b0};
            cnt_q  <= cnt_q + CW'(1);
         end
      end
   end

   assign miso_o = miso_q;
   assign done_o = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: MOSI frames to 10-bit RAM words, read data out on MISO
// Optional feature macro: SPI_FRAME_ERR_EN (adds frame_err output).
// Ports:
//   clk, rst_n  : system/SPI bit clock, asynchronous active-low reset
//   SS_n        : slave select, active low
//   MOSI / MISO : serial in (sampled on rising clk) / serial out (updated on rising clk)
//   rx_data     : last complete received word {opcode[1:0], payload[7:0]}
//   rx_valid    : one-cycle strobe when rx_data is updated
//   frame_err   : (SPI_FRAME_ERR_EN only) one-cycle pulse when SS_n rises mid-frame
//   tx_data     : read data from the RAM
//   tx_valid    : tx_data valid, accepted only while waiting in READ_DATA
module spi_slave
   import spi_pkg::*;
#(
   parameter int RX_WIDTH = RX_WIDTH_DEF,
   parameter int TX_WIDTH = TX_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                SS_n,
   input  logic                MOSI,
   output logic                MISO,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
`ifdef SPI_FRAME_ERR_EN
   output logic                frame_err,
`endif
   input  logic [TX_WIDTH-1:0] tx_data,
   input  logic                tx_valid
);

   localparam int CNT_W = $clog2(RX_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_WIDTH - 1);

   spi_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RX_WIDTH-2:0] shift_q, shift_d;
   logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                rd_addr_seen_q, rd_addr_seen_d;
   // word_done: the 10-bit word of this frame has been delivered
   logic                word_done_q, word_done_d;
   // tx_started: read data already accepted in this frame, later tx_valid ignored
   logic                tx_started_q, tx_started_d;

   logic                ser_load;
   logic                ser_abort;
   logic                ser_done;

   assign ser_abort = (state_q != IDLE) && SS_n;
   assign ser_load  = (state_q == READ_DATA) && !SS_n && word_done_q
                      && !tx_started_q && tx_valid;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      shift_d        = shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      word_done_d    = word_done_q;
      tx_started_d   = tx_started_q;

      // Once the last MISO bit is on the wire the read is consumed, even if
      // SS_n rises on this same edge.
      if (ser_done) begin
         rd_addr_seen_d = 1'b0;
      end

      if (state_q == IDLE) begin
         if (!SS_n) begin
            state_d = CHK_CMD;
         end
      end else if (SS_n) begin
         state_d      = IDLE;
         cnt_d        = '0;
         word_done_d  = 1'b0;
         tx_started_d = 1'b0;
      end else begin
         case (state_q)
            CHK_CMD: begin
               if (!MOSI) begin
                  state_d = WRITE;
               end else if (rd_addr_seen_q) begin
                  state_d = READ_DATA;
               end else begin
                  state_d = READ_ADD;
               end
            end
            default: begin
               if (!word_done_q) begin
                  if (cnt_q == LAST_BIT) begin
                     rx_data_d   = {shift_q, MOSI};
                     rx_valid_d  = 1'b1;
                     word_done_d = 1'b1;
                     cnt_d       = '0;
                     if (state_q == READ_ADD) begin
                        rd_addr_seen_d = 1'b1;
                     end
                  end else begin
                     shift_d = {shift_q[RX_WIDTH-3:0], MOSI};
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end else if (ser_load) begin
                  tx_started_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         shift_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rd_addr_seen_q <= 1'b0;
         word_done_q    <= 1'b0;
         tx_started_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         shift_q        <= shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         word_done_q    <= word_done_d;
         tx_started_q   <= tx_started_d;
      end
   end

   spi_tx_serializer #(
      .TX_WIDTH (TX_WIDTH)
   ) u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ser_load),
      .abort_i   (ser_abort),
      .tx_data_i (tx_data),
      .miso_o    (MISO),
      .done_o    (ser_done)
   );

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
   // tx_fin: all MISO bits of this frame have been sent
   logic tx_fin_q;
   logic frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_fin_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (ser_abort) begin
            tx_fin_q <= 1'b0;
            case (state_q)
               WRITE, READ_ADD: frame_err_q <= !word_done_q;
               READ_DATA:       frame_err_q <= !(tx_fin_q || ser_done);
               default:         frame_err_q <= 1'b1;
            endcase
         end else if (ser_done) begin
            tx_fin_q <= 1'b1;
         end
      end
   end

   assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
   import spi_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
   logic       frame_err;
`endif

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_rx[$];
   logic       exp_miso[$];

   spi_slave dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
`ifdef SPI_FRAME_ERR_EN
      .frame_err (frame_err),
`endif
      .tx_data   (tx_data),
      .tx_valid  (tx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every rx_valid strobe must match the oldest word the bench sent.
   always @(negedge clk) begin
      if (rst_n && rx_valid === 1'b1) begin
         checks++;
         assert (exp_rx.size() != 0) else begin
            failures++;
            $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
         end
         if (exp_rx.size() != 0) begin
            chk("rx_word", rx_data, exp_rx.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      MOSI = b;
      tick();
   endtask

   task automatic start_frame(input logic cmd);
      SS_n = 1'b0;
      tick();
      send_bit(cmd);
   endtask

   task automatic send_word(input logic [9:0] w);
      exp_rx.push_back(w);
      for (int i = 9; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      tick();
   endtask

   task automatic miso_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, MISO, 1'b0);
         tick();
      end
   endtask

   task automatic load_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 7; i >= 0; i--) exp_miso.push_back(d[i]);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic expect_miso(input int n);
      for (int i = 0; i < n; i++) begin
         chk("miso_bit", MISO, exp_miso.pop_front());
         tick();
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tick();
      tick();
      chk("reset_miso", MISO, 1'b0);
      chk("reset_rx_data", rx_data, 10'h000);
      chk("reset_rx_valid", rx_valid, 1'b0);
      rst_n = 1'b1;
      tick();

      // Write address, trailing bits ignored.
      start_frame(1'b0);
      send_word({OP_WR_ADDR, 8'h05});
      send_bit(1'b1);
      send_bit(1'b0);
      miso_quiet("wr_addr_miso", 2);
      end_frame();
      chk("wr_addr_hold", rx_data, 10'h005);

      // Write data with tx_valid held high: must not reach MISO.
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      start_frame(1'b0);
      chk("wr_txv_miso0", MISO, 1'b0);
      send_word({OP_WR_DATA, 8'hAA});
      miso_quiet("wr_txv_miso", 3);
      end_frame();
      tx_valid = 1'b0;
      chk("wr_data_hold", rx_data, 10'h1AA);
      chk("wr_data_valid_low", rx_valid, 1'b0);

      // Read address then read data with full serialization.
      start_frame(1'b1);
      send_word({OP_RD_ADDR, 8'h05});
      end_frame();
      start_frame(1'b1);
      send_word(10'h3A5);
      chk("rd_opcode", rx_data[9:8], OP_RD_DATA);
      miso_quiet("rd_wait_miso", 2);
      load_tx(8'hC3);
      expect_miso(8);
      chk("rd_after_miso", MISO, 1'b0);
      tick();
      end_frame();
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_complete_rd", frame_err, 1'b0);
`endif

      // rd_addr_seen cleared: next read frame is an address frame.
      start_frame(1'b1);
      send_word({OP_RD_ADDR, 8'hF0});
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      miso_quiet("rdadd_txv_miso", 3);
      tx_valid = 1'b0;
      end_frame();

      // Abort a write after 6 bits.
      start_frame(1'b0);
      for (int i = 0; i < 6; i++) send_bit(i[0]);
      end_frame();
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_abort_wr", frame_err, 1'b1);
`endif
      chk("abort_rx_valid", rx_valid, 1'b0);
      start_frame(1'b0);
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_pulse_end", frame_err, 1'b0);
`endif
      send_word({OP_WR_ADDR, 8'hF0});
      end_frame();
      chk("post_abort_word", rx_data, 10'h0F0);

      // SS_n rises together with the 10th bit: word discarded.
      start_frame(1'b0);
      for (int i = 0; i < 9; i++) send_bit(1'b1);
      MOSI = 1'b1;
      end_frame();
      chk("ss_on_10th_valid", rx_valid, 1'b0);
      chk("ss_on_10th_hold", rx_data, 10'h0F0);
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_10th", frame_err, 1'b1);
`endif

      // Abort mid-MISO shift: rd_addr_seen kept, next read is data again.
      start_frame(1'b1);
      send_word(10'h3C3);
      load_tx(8'h5A);
      expect_miso(3);
      end_frame();
      chk("abort_shift_miso", MISO, 1'b0);
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_abort_rd", frame_err, 1'b1);
`endif
      exp_miso.delete();

      // Reset during READ_DATA shift.
      start_frame(1'b1);
      send_word(10'h311);
      load_tx(8'hA5);
      expect_miso(3);
      exp_miso.delete();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_miso", MISO, 1'b0);
      chk("rst_mid_rx_valid", rx_valid, 1'b0);
      chk("rst_mid_rx_data", rx_data, 10'h000);
      SS_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      // After reset the read frame must be an address frame.
      start_frame(1'b1);
      send_word({OP_RD_ADDR, 8'hAA});
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      miso_quiet("post_rst_rdadd_miso", 3);
      tx_valid = 1'b0;
      end_frame();
      start_frame(1'b1);
      send_word(10'h3FF);
      load_tx(8'h96);
      expect_miso(8);
      chk("post_rst_miso_end", MISO, 1'b0);
      end_frame();
`ifdef SPI_FRAME_ERR_EN
      chk("ferr_complete_rd2", frame_err, 1'b0);
`endif

      tick();
      chk("rx_queue_drained", exp_rx.size(), 0);
      chk("miso_queue_drained", exp_miso.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
